// File: rtl/srl_pkg.sv
// Shared constants and types for the shift-register FIFO.
// WIDTH is a module parameter. Depth and count width are fixed here.
package srl_pkg;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ADDR_W = 5;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  // The oldest word sits at index cnt-1. Wrapping at cnt=32 gives address 31.
  function automatic addr_t oldest_addr(input cnt_t cnt);
    return addr_t'(cnt[ADDR_W-1:0] - addr_t'(1));
  endfunction

endpackage

// File: rtl/srl_fifo32_srlc32e.sv
// Behavioural model of a 32-bit addressable shift register with clock enable (SRLC32E).
// The contents have no reset.
module SRLC32E (
  input  logic       CLK,
  input  logic       CE,
  input  logic [4:0] A,
  input  logic       D,
  output logic       Q,
  output logic       Q31
);

  logic [31:0] sr_q;

  always_ff @(posedge CLK) begin
    if (CE) sr_q <= {sr_q[30:0], D};
  end

  assign Q   = sr_q[A];
  assign Q31 = sr_q[31];

endmodule

// File: rtl/srl_fifo32.sv
// 32-deep FIFO built from per-bit addressable shift registers, followed by one output register.
// LEVEL counts the words in the shift array plus the word in the output register.
module srl_fifo32
  import srl_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] INIT_DATA = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic [WIDTH-1:0] S_DATA,
  output logic             M_VALID,
  input  logic             M_READY,
  output logic [WIDTH-1:0] M_DATA,
  output logic [5:0]       LEVEL
);

  cnt_t             cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;

  logic             push, pop;
  addr_t            rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] srl_q31_unused;

  assign S_READY = (cnt_q != CNT_FULL) && !RST;
  assign push    = S_VALID && S_READY;
  assign pop     = (cnt_q != '0) && (!m_valid_q || M_READY);
  assign rd_addr = oldest_addr(cnt_q);

  for (genvar b = 0; b < WIDTH; b++) begin : g_srl
    SRLC32E u_srl (
      .CLK (CLK),
      .CE  (push),
      .A   (rd_addr),
      .D   (S_DATA[b]),
      .Q   (rd_data[b]),
      .Q31 (srl_q31_unused[b])
    );
  end

  // rd_data is read before the shift on this edge, so a simultaneous push cannot disturb it.
  always_comb begin
    cnt_d     = cnt_q + cnt_t'(push) - cnt_t'(pop);
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (pop) begin
      m_valid_d = 1'b1;
      m_data_d  = rd_data;
    end else if (M_READY) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= INIT_DATA;
    end else begin
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign M_VALID = m_valid_q;
  assign M_DATA  = m_data_q;
  assign LEVEL   = cnt_q + cnt_t'(m_valid_q);

endmodule

// File: tb/tb_srl_fifo32.sv
// Directed bench for srl_fifo32. It covers reset, latency, fill and drain, streaming, the full boundary and a mid-operation reset.
module tb_srl_fifo32;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] INIT = 8'h5A;

  logic             clk_sys;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [5:0]       level;

  int n_chk;
  int n_pass;

  srl_fifo32 #(.WIDTH(WIDTH), .INIT_DATA(INIT)) u_dut (
    .CLK     (clk_sys),
    .RST     (rst),
    .S_VALID (s_valid),
    .S_READY (s_ready),
    .S_DATA  (s_data),
    .M_VALID (m_valid),
    .M_READY (m_ready),
    .M_DATA  (m_data),
    .LEVEL   (level)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    m_ready = 1'b1;

    // reset: inputs are ignored while RST is high
    step();
    step();
    chk_eq("rst_level", 64'(level), 64'd0);
    chk_eq("rst_mvalid", 64'(m_valid), 64'd0);
    chk_eq("rst_mdata", 64'(m_data), 64'(INIT));
    chk_eq("rst_sready", 64'(s_ready), 64'd0);
    rst     = 1'b0;
    s_valid = 1'b0;
    #1;
    chk_eq("post_rst_sready", 64'(s_ready), 64'd1);

    // latency: push at edge k, the word is visible after edge k+1
    s_valid = 1'b1;
    s_data  = 8'hA5;
    step();
    s_valid = 1'b0;
    chk_eq("lat_k_mvalid", 64'(m_valid), 64'd0);
    chk_eq("lat_k_level", 64'(level), 64'd1);
    step();
    chk_eq("lat_k1_mvalid", 64'(m_valid), 64'd1);
    chk_eq("lat_k1_mdata", 64'(m_data), 64'hA5);
    chk_eq("lat_k1_level", 64'(level), 64'd1);
    step();
    chk_eq("lat_consumed", 64'(m_valid), 64'd0);

    // fill 33 words with the output stalled, then drain them
    m_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      chk_eq("fill_sready", 64'(s_ready), 64'd1);
      step();
    end
    s_valid = 1'b0;
    chk_eq("full_sready", 64'(s_ready), 64'd0);
    chk_eq("full_level", 64'(level), 64'd33);
    chk_eq("full_mdata", 64'(m_data), 64'h00);
    m_ready = 1'b1;
    for (int i = 0; i < 33; i++) begin
      chk_eq("drain_mvalid", 64'(m_valid), 64'd1);
      chk_eq("drain_mdata", 64'(m_data), 64'(i));
      step();
      if (i == 0) chk_eq("drain_sready_back", 64'(s_ready), 64'd1);
    end
    chk_eq("drained_mvalid", 64'(m_valid), 64'd0);
    chk_eq("drained_level", 64'(level), 64'd0);

    // streaming: one word per cycle, level stays at 2
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      step();
      if (i == 0) begin
        chk_eq("stream_level0", 64'(level), 64'd1);
      end else begin
        chk_eq("stream_mvalid", 64'(m_valid), 64'd1);
        chk_eq("stream_mdata", 64'(m_data), 64'(i - 1));
        chk_eq("stream_level", 64'(level), 64'd2);
      end
    end
    s_valid = 1'b0;
    step();
    chk_eq("stream_last", 64'(m_data), 64'd99);
    chk_eq("stream_last_level", 64'(level), 64'd1);
    step();
    chk_eq("stream_empty", 64'(m_valid), 64'd0);

    // full boundary: a push offered while full is refused, then accepted next cycle
    m_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h40 + i);
      step();
    end
    s_data  = 8'h80;
    m_ready = 1'b1;
    chk_eq("bnd_refused", 64'(s_ready), 64'd0);
    chk_eq("bnd_level33", 64'(level), 64'd33);
    step();
    chk_eq("bnd_sready_next", 64'(s_ready), 64'd1);
    chk_eq("bnd_level_after", 64'(level), 64'd32);
    chk_eq("bnd_mdata_41", 64'(m_data), 64'h41);
    step();
    s_valid = 1'b0;
    chk_eq("bnd_level_steady", 64'(level), 64'd32);
    for (int v = 8'h42; v <= 8'h60; v++) begin
      chk_eq("bnd_drain", 64'(m_data), 64'(v));
      step();
    end
    chk_eq("bnd_tail_mvalid", 64'(m_valid), 64'd1);
    chk_eq("bnd_tail", 64'(m_data), 64'h80);
    step();
    chk_eq("bnd_empty", 64'(m_valid), 64'd0);

    // mid-operation reset with ten words held
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h10 + i);
      step();
    end
    s_valid = 1'b0;
    chk_eq("mid_level10", 64'(level), 64'd10);
    rst = 1'b1;
    step();
    chk_eq("mid_rst_level", 64'(level), 64'd0);
    chk_eq("mid_rst_mvalid", 64'(m_valid), 64'd0);
    chk_eq("mid_rst_mdata", 64'(m_data), 64'(INIT));
    rst = 1'b0;
    #1;
    chk_eq("mid_post_sready", 64'(s_ready), 64'd1);
    chk_eq("mid_post_level", 64'(level), 64'd0);
    s_valid = 1'b1;
    s_data  = 8'h3C;
    m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    step();
    chk_eq("mid_next_mvalid", 64'(m_valid), 64'd1);
    chk_eq("mid_next_mdata", 64'(m_data), 64'h3C);
    step();
    chk_eq("mid_final_level", 64'(level), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/srl_fifo32.md
SRL_FIFO32 -- requirements
Module: srl_fifo32

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits (1..64).
REQ-002 SHALL have parameter INIT_DATA, default all-zero WIDTH bits, meaning the M_DATA value after reset.
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port S_VALID  input  1  upstream word valid.
REQ-006 SHALL have port S_READY  output  1  block can accept a word.
REQ-007 SHALL have port S_DATA  input  WIDTH  upstream word.
REQ-008 SHALL have port M_VALID  output  1  output register holds a word.
REQ-009 SHALL have port M_READY  input  1  downstream accepts the word.
REQ-010 SHALL have port M_DATA  output  WIDTH  registered output word.
REQ-011 SHALL have port LEVEL  output  6  total words held (shift-register words plus output register), 0..33.

Function
REQ-012 SHALL store words in a 32-deep shift-register array, one 32-bit shift register per data bit, with a common clock enable and a common 5-bit read address.
REQ-013 SHALL keep a registered 6-bit count CNT (0..32) of words in the shift-register array.
REQ-014 SHALL drive S_READY = (CNT != 32) and not RST.
REQ-015 SHALL define push = S_VALID & S_READY; the shift enable SHALL equal push, and the shift input SHALL equal S_DATA.
REQ-016 SHALL drive the shift read address = CNT-1 (5 bits), don't-care when CNT = 0; the word at that address is always the oldest.
REQ-017 SHALL define pop = (CNT != 0) & (!M_VALID | M_READY).
REQ-018 SHALL, on pop, load M_DATA with the oldest word, sampled before the same-edge shift, and set M_VALID.
REQ-019 SHALL clear M_VALID when M_READY is high and no pop occurs; M_DATA SHALL hold while M_VALID & !M_READY.
REQ-020 SHALL update CNT <= CNT + push - pop; simultaneous push and pop leave CNT unchanged and return the correct oldest word.
REQ-021 SHALL drive LEVEL = CNT + M_VALID, combinational from registers.
REQ-022 SHALL have latency: word pushed at edge k appears on M_DATA with M_VALID after edge k+1 when the block was empty.
REQ-023 SHALL, when full (CNT = 32), accept no push; pop in that cycle frees a slot visible as S_READY=1 the next cycle, never the same cycle.
REQ-024 SHALL never lose, duplicate or reorder words; throughput is one word per cycle in steady state.

Reset
REQ-025 SHALL, while RST is high, force CNT=0, M_VALID=0, M_DATA=INIT_DATA, S_READY=0, and ignore S_VALID and M_READY.
REQ-026 SHALL NOT reset the shift-register contents; stale contents SHALL never reach M_DATA.
REQ-027 SHALL, on RST asserted mid-operation, discard all held words at that edge; the first cycle after RST deasserts has S_READY=1, LEVEL=0.

Structure
REQ-028 SHALL place depth constant 32 and count width 6 in the shared package srl_pkg; WIDTH stays a module parameter.
REQ-029 SHALL instantiate the team's SRLC32E model WIDTH times (generate loop), Q used as read data, Q31 unused; no other sub-module.
REQ-030 SHALL be synthesizable and lint-clean under Verilator with no latches.

Verification
REQ-031 SHALL test reset: RST 2 cycles -> LEVEL=0, M_VALID=0, M_DATA=INIT_DATA, S_READY=0 during RST, 1 after.
REQ-032 SHALL test latency: push 0xA5 into empty at edge k, M_READY=1 -> M_VALID=1, M_DATA=0xA5 after edge k+1, LEVEL=1.
REQ-033 SHALL test fill: M_READY=0, push 0x00..0x20 (33 words) -> S_READY=0 after 33rd push, LEVEL=33, M_DATA=0x00; drain returns 0x00..0x20 in order.
REQ-034 SHALL test streaming: continuous push 0..99 with M_READY=1 -> one word out per cycle, in order, LEVEL stays at most 2.
REQ-035 SHALL test full boundary: CNT=32, M_VALID=1, M_READY=1, S_VALID=1 -> push refused that cycle, accepted the next, no loss.
REQ-036 SHALL test mid-operation reset: RST at LEVEL=10 -> LEVEL=0 next cycle; the next pushed word 0x3C is the next word output.
